fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Fetch controller that drives the instruction pointer and sequences instruction fetch from program memory. It issues the IP value as a memory read address and captures the returned word into an instruction register. It hands the word to the decoder via a valid/ack handshake, then pulses inc_ip. It also redirects the IP on branch requests, handles halt/resume, and flags memory timeouts.

Parameters:
ADDR_WIDTH, 16, width of IP / memory address
INSTR_WIDTH, 16, width of instruction word
RESET_VECTOR, 16'h0000, address loaded into the IP after reset
MAX_WAIT, 15, max cycles mem_req may stay unanswered before error (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ip_value  in  ADDR_WIDTH  current IP output (ip_data_out of the IP)
load_ip  out  1  IP load strobe
inc_ip  out  1  IP increment strobe
ip_load_value  out  ADDR_WIDTH  value for IP load (ip_data_in)
mem_req  out  1  read request, held until mem_ready or abort
mem_addr  out  ADDR_WIDTH  read address (= ip_value while mem_req)
mem_ready  in  1  read data valid this cycle
mem_rdata  in  INSTR_WIDTH  read data
instr_out  out  INSTR_WIDTH  captured instruction
instr_valid  out  1  instr_out valid to decoder
instr_ack  in  1  decoder consumes instr_out this cycle
branch_req  in  1  redirect request
branch_target  in  ADDR_WIDTH  redirect address
halt  in  1  stop fetching at next instruction boundary
halted  out  1  sequencer is in HALTED
fetch_err  out  1  sticky timeout flag

Behaviour:
- States: BOOT, FETCH, HOLD, HALTED, ERROR. Reset (async, reset_n=0) forces BOOT, instr_out=0, wait counter=0, fetch_err=0.
- Outputs mem_req, instr_valid, halted, fetch_err are decoded from registered state. load_ip, inc_ip and ip_load_value are Mealy (combinational from state plus inputs).
- During reset: all strobes 0, mem_req=0, instr_valid=0, halted=0.
- BOOT: load_ip=1, ip_load_value=RESET_VECTOR for exactly one cycle -> FETCH.
- FETCH: mem_req=1, mem_addr=ip_value; wait counter increments each cycle without mem_ready.
  - mem_ready=1: capture mem_rdata into instr_out, inc_ip=1 (same cycle), counter cleared -> HOLD.
  - Counter reaches MAX_WAIT without mem_ready -> ERROR. mem_ready on that same cycle wins.
- HOLD: instr_valid=1, instr_out stable.
  - instr_ack=1 with halt=0 -> FETCH.
  - instr_ack=1 with halt=1 -> HALTED.
  - No ack: stay in HOLD indefinitely.
- HALTED: halted=1, no requests. branch_req -> redirect (below). halt deassertion alone does not resume.
- ERROR: fetch_err=1, mem_req=0, instr_valid=0. Only reset exits.
- Branch (in FETCH, HOLD, HALTED): load_ip=1, ip_load_value=branch_target, inc_ip=0, next state FETCH, counter cleared.
  - In FETCH: the outstanding read is aborted (mem_req drops one cycle is not required; the next FETCH cycle addresses the new IP). A coincident mem_ready is discarded and instr_out is not updated.
  - In HOLD: the held instruction is dropped; a coincident instr_ack is ignored for halt purposes.
  - branch_req in BOOT/ERROR is ignored.
- Invariant: load_ip and inc_ip are never both 1.
- Latency: reset release -> first mem_req = 2 cycles (BOOT, then FETCH). With zero-wait memory, one instruction per 2 cycles when ack is immediate.
- Address width: ip_value is passed through unmodified; IP wrap (FFFF -> 0000) is the IP's concern and is not checked here.

Decomposition:
- Shared package cpu_pkg: fetch_state_t enum (BOOT, FETCH, HOLD, HALTED, ERROR), RESET_VECTOR default, ADDR_WIDTH/INSTR_WIDTH constants.
- No sub-module needed. Optionally factor a wait_timer (saturating counter with clear) if reused by other bus masters.
- Bench instantiates this block with the existing instruction_pointer and a behavioural memory with programmable latency.

Test Plan:
- Reset release, RESET_VECTOR=16'h1000, memory 0-wait returning addr^16'hA5A5 -> load_ip 1 cycle; mem_addr=1000; instr_out=B5A5; IP=1001 after ack; next mem_addr=1001.
- 3-cycle memory latency, decoder acks after 2 cycles in HOLD -> mem_req held 3 cycles; inc_ip single pulse; instr_valid held until ack; no duplicate fetch.
- branch_req with target 16'h3500 on the same cycle as mem_ready -> instr_out unchanged, no inc_ip, load_ip=1, next mem_addr=3500.
- halt=1 with ack at IP=1004 -> HALTED, mem_req stays 0 for 20 cycles; then branch_req target 16'h2000 -> FETCH at 2000, halted=0.
- Memory never responds, MAX_WAIT=15 -> ERROR after 15 FETCH cycles; fetch_err=1 and stays set through a later branch_req; reset_n pulse clears it and restarts at BOOT.
- reset_n asserted mid-HOLD (asynchronous, between edges) -> instr_valid/mem_req drop immediately; after release, sequence restarts from RESET_VECTOR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and default constants for the fetch path.
package cpu_pkg;

    localparam int              CPU_ADDR_WIDTH   = 16;
    localparam int              CPU_INSTR_WIDTH  = 16;
    localparam logic [15:0]     CPU_RESET_VECTOR = 16'h0000;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_HALTED,
        ST_ERROR
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// Saturating wait counter: runs while count is high, clears when it drops,
// and flags the cycle on which the LIMIT-th consecutive count lands.
module fetch_sequencer_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!count) begin
            cnt <= '0;
        end else if (cnt != W'(LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Combinational so a read that has already waited LIMIT-1 cycles
    // expires on its LIMIT-th cycle, not one later.
    assign expire = count && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: drives the IP, fetches from program memory,
// hands words to the decoder, and handles branch, halt and read timeouts.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = CPU_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH  = CPU_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(CPU_RESET_VECTOR),
    parameter int                    MAX_WAIT     = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_WIDTH-1:0]  ip_value,
    output logic                   load_ip,
    output logic                   inc_ip,
    output logic [ADDR_WIDTH-1:0]  ip_load_value,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ack,
    input  logic                   branch_req,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt,
    output logic                   halted,
    output logic                   fetch_err
);

    fetch_state_t state, state_nxt;
    logic         take_branch;
    logic         capture;
    logic         wait_count;
    logic         timeout;

    // A branch outranks a coincident mem_ready or instr_ack.
    assign take_branch = branch_req &&
                         (state == ST_FETCH || state == ST_HOLD || state == ST_HALTED);
    assign capture     = (state == ST_FETCH) && mem_ready && !take_branch;
    assign wait_count  = (state == ST_FETCH) && !mem_ready && !take_branch;

    fetch_sequencer_wait_timer #(
        .LIMIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .count   (wait_count),
        .expire  (timeout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:   state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (take_branch)    state_nxt = ST_FETCH;
                else if (mem_ready) state_nxt = ST_HOLD;
                else if (timeout)   state_nxt = ST_ERROR;
            end
            ST_HOLD: begin
                if (take_branch)    state_nxt = ST_FETCH;
                else if (instr_ack) state_nxt = halt ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: begin
                if (take_branch)    state_nxt = ST_FETCH;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_ERROR;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state register and drop immediately on async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_BOOT;
            instr_out   <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            if (capture) instr_out <= mem_rdata;
            mem_req     <= (state_nxt == ST_FETCH);
            instr_valid <= (state_nxt == ST_HOLD);
            halted      <= (state_nxt == ST_HALTED);
            fetch_err   <= (state_nxt == ST_ERROR);
        end
    end

    // BOOT is also the reset state, so the load strobe is masked by reset_n.
    assign load_ip       = reset_n && ((state == ST_BOOT) || take_branch);
    assign inc_ip        = capture;
    assign ip_load_value = (state == ST_BOOT) ? RESET_VECTOR : branch_target;
    assign mem_addr      = ip_value;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: IP register, variable-latency memory and a
// rule-level reference model checked every cycle, plus directed scenarios.
module tb_fetch_sequencer;

    localparam logic [15:0] RV = 16'h1000;
    localparam int          MW = 15;
    localparam int M_BOOT = 0, M_FETCH = 1, M_HOLD = 2, M_HALT = 3, M_ERR = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] ip_value;
    logic        load_ip, inc_ip;
    logic [15:0] ip_load_value;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        branch_req = 1'b0;
    logic [15:0] branch_target = 16'h0;
    logic        halt = 1'b0;
    logic        halted, fetch_err;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_WIDTH(16), .INSTR_WIDTH(16), .RESET_VECTOR(RV), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ip_value(ip_value), .load_ip(load_ip),
        .inc_ip(inc_ip), .ip_load_value(ip_load_value), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .branch_req(branch_req), .branch_target(branch_target), .halt(halt),
        .halted(halted), .fetch_err(fetch_err)
    );

    // Instruction pointer register driven by the DUT strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     ip_value <= 16'h0;
        else if (load_ip) ip_value <= ip_load_value;
        else if (inc_ip)  ip_value <= ip_value + 16'd1;
    end

    // Memory: answers after mem_lat cycles of request, or never when dead.
    int   mem_cnt = 0;
    int   mem_lat = 1;
    logic mem_dead = 1'b0;
    always_ff @(posedge clk) begin
        if (!mem_req || mem_ready || load_ip) mem_cnt <= 0;
        else                                  mem_cnt <= mem_cnt + 1;
    end
    assign mem_ready = mem_req && !mem_dead && (mem_cnt >= mem_lat - 1);
    assign mem_rdata = mem_addr ^ 16'hA5A5;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_mode = M_BOOT;
    logic [15:0] m_ip = 16'h0;
    logic [15:0] m_instr = 16'h0;
    int          m_wait = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at negedge, advance the model.
    task automatic tick();
        logic        rdy, br, ack, hl, e_load;
        logic [15:0] tgt;
        @(negedge clk);
        rdy = mem_ready; br = branch_req; ack = instr_ack; hl = halt; tgt = branch_target;
        e_load = (m_mode == M_BOOT) ||
                 (br && (m_mode == M_FETCH || m_mode == M_HOLD || m_mode == M_HALT));
        chk1("mem_req", mem_req, m_mode == M_FETCH);
        chk1("instr_valid", instr_valid, m_mode == M_HOLD);
        chk1("halted", halted, m_mode == M_HALT);
        chk1("fetch_err", fetch_err, m_mode == M_ERR);
        chk16("instr_out", instr_out, m_instr);
        chk1("load_ip", load_ip, e_load);
        chk1("inc_ip", inc_ip, m_mode == M_FETCH && rdy && !br);
        if (e_load) chk16("ip_load_value", ip_load_value, (m_mode == M_BOOT) ? RV : tgt);
        if (m_mode == M_FETCH) chk16("mem_addr", mem_addr, m_ip);
        case (m_mode)
            M_BOOT: begin m_ip = RV; m_mode = M_FETCH; end
            M_FETCH: begin
                if (br) begin
                    m_ip = tgt; m_wait = 0;
                end else if (rdy) begin
                    m_instr = m_ip ^ 16'hA5A5; m_ip = m_ip + 16'd1;
                    m_wait = 0; m_mode = M_HOLD;
                end else begin
                    m_wait++;
                    if (m_wait == MW) m_mode = M_ERR;
                end
            end
            M_HOLD: begin
                if (br)       begin m_ip = tgt; m_mode = M_FETCH; end
                else if (ack) m_mode = hl ? M_HALT : M_FETCH;
            end
            M_HALT: if (br) begin m_ip = tgt; m_mode = M_FETCH; end
            default: ;
        endcase
        @(posedge clk); #1;
    endtask

    // Assert reset between edges, check the reset state, release after a posedge.
    task automatic apply_reset(input int dly);
        #(dly) reset_n = 1'b0;
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_fetch_err", fetch_err, 1'b0);
        chk1("rst_load_ip", load_ip, 1'b0);
        chk1("rst_inc_ip", inc_ip, 1'b0);
        chk16("rst_instr_out", instr_out, 16'h0);
        m_mode = M_BOOT; m_instr = 16'h0; m_wait = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int          nreq;
        logic [15:0] old_instr;

        apply_reset(2);

        // Zero-wait fetch, immediate ack
        instr_ack = 1'b1;
        tick();
        tick();
        chk16("first_instr", instr_out, 16'hB5A5);
        tick();
        chk16("ip_after_ack", ip_value, 16'h1001);
        chk16("second_addr", mem_addr, 16'h1001);

        // 3-cycle memory, decoder waits 2 cycles in HOLD
        mem_lat = 3; instr_ack = 1'b0; nreq = 0;
        for (int i = 0; i < 10 && !instr_valid; i++) begin
            if (mem_req) nreq++;
            tick();
        end
        chk16("lat3_req_cycles", 16'(nreq), 16'd3);
        tick(); tick();
        instr_ack = 1'b1; tick(); instr_ack = 1'b0;

        // Branch on the same cycle as mem_ready
        for (int i = 0; i < 10 && !(mem_req && mem_ready); i++) tick();
        old_instr = instr_out;
        branch_req = 1'b1; branch_target = 16'h3500;
        tick();
        branch_req = 1'b0;
        chk16("br_instr_kept", instr_out, old_instr);
        chk16("br_new_addr", mem_addr, 16'h3500);

        // Halt at an ack, stay halted, resume only by branch
        mem_lat = 1; instr_ack = 1'b1; halt = 1'b1;
        for (int i = 0; i < 20 && !halted; i++) tick();
        chk1("halt_reached", halted, 1'b1);
        instr_ack = 1'b0; halt = 1'b0; nreq = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) nreq++;
            tick();
        end
        chk16("halted_no_req", 16'(nreq), 16'd0);
        branch_req = 1'b1; branch_target = 16'h2000;
        tick();
        branch_req = 1'b0;
        chk1("resume_halted", halted, 1'b0);
        chk16("resume_addr", mem_addr, 16'h2000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            instr_ack     = ($urandom_range(0, 2) != 0);
            halt          = ($urandom_range(0, 15) == 0);
            branch_req    = ($urandom_range(0, 9) == 0);
            branch_target = 16'($urandom);
            mem_lat       = $urandom_range(1, 4);
            tick();
        end
        instr_ack = 1'b0; halt = 1'b0;

        // Memory never answers
        branch_req = 1'b1; branch_target = 16'h4000;
        tick();
        branch_req = 1'b0; mem_dead = 1'b1; nreq = 0;
        for (int i = 0; i < 40 && !fetch_err; i++) begin
            if (mem_req) nreq++;
            tick();
        end
        chk16("timeout_cycles", 16'(nreq), 16'(MW));
        chk1("timeout_err", fetch_err, 1'b1);
        branch_req = 1'b1; branch_target = 16'h5000;
        tick();
        branch_req = 1'b0;
        tick();
        chk1("err_sticky", fetch_err, 1'b1);
        chk1("err_no_req", mem_req, 1'b0);
        mem_dead = 1'b0;
        apply_reset(3);

        // Async reset in the middle of HOLD
        mem_lat = 1;
        tick(); tick();
        chk1("pre_rst_hold", instr_valid, 1'b1);
        apply_reset(2);
        tick();
        chk16("restart_addr", mem_addr, RV);
        tick();
        chk16("restart_instr", instr_out, RV ^ 16'hA5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
